// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the WISC pipeline sequencing controller:
// sequencer state encoding, register-specifier width, the hard-wired
// zero register, and canned per-stage control bundles.
package hazard_ctrl_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    HALT  = 2'd3
  } hz_state_e;

  // One bundle holding every pipeline enable/flush/bubble plus halted.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
    logic halted;
  } hz_ctl_t;

  // Everything advances, nothing is squashed.
  function automatic hz_ctl_t ctl_normal();
    return '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
             ex_mem_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0,
             mem_wb_bubble: 1'b0, halted: 1'b0};
  endfunction

  // Front end held, a NOP slides into EX (load-use or fetch wait).
  function automatic hz_ctl_t ctl_stall();
    return '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
             ex_mem_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b1,
             mem_wb_bubble: 1'b0, halted: 1'b0};
  endfunction

  // Whole pipe up to MEM frozen, WB receives a NOP (data-memory wait).
  function automatic hz_ctl_t ctl_freeze();
    return '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
             ex_mem_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0,
             mem_wb_bubble: 1'b1, halted: 1'b0};
  endfunction

  // PC loads the branch target, the fall-through fetch is squashed.
  function automatic hz_ctl_t ctl_branch();
    return '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
             ex_mem_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b0,
             mem_wb_bubble: 1'b0, halted: 1'b0};
  endfunction

  // Reset fills the pipe with NOPs while holding the PC at its reset value.
  function automatic hz_ctl_t ctl_reset();
    return '{pc_write: 1'b0, if_id_write: 1'b1, id_ex_write: 1'b1,
             ex_mem_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1,
             mem_wb_bubble: 1'b1, halted: 1'b0};
  endfunction

  // Halted core: nothing moves, nothing is injected.
  function automatic hz_ctl_t ctl_halt();
    return '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
             ex_mem_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0,
             mem_wb_bubble: 1'b0, halted: 1'b1};
  endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use comparator: flags an instruction in ID that reads the
// destination of a load currently in EX. Register 0 never hazards.
// Kept separate so a second issue slot can instantiate another copy.
module hazard_lu_detect #(
  parameter int REG_W = hazard_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             rs_valid_i,
  input  logic             rt_valid_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             mem_read_i,
  output logic             lu_o
);
  import hazard_ctrl_pkg::*;

  // Compare each actually-read source field against the load destination.
  always_comb begin
    lu_o = mem_read_i && (rd_i != REG_W'(ZERO_REG)) &&
           ((rs_valid_i && (rs_i == rd_i)) || (rt_valid_i && (rt_i == rd_i)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage WISC core.
// Produces every per-stage write enable, flush and bubble from load-use
// hazards, ID-resolved taken branches and instruction/data memory misses,
// and latches the core halted when HLT retires.
// Optional build macro HAZARD_PERF_EN adds saturating stall_cycles and
// flush_count performance counters (ports and logic absent otherwise).
module hazard_ctrl #(
  parameter int REG_W = hazard_ctrl_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             IF_ID_RsValid,
  input  logic             IF_ID_RtValid,
  input  logic [REG_W-1:0] ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             branch_taken,
  input  logic             imem_miss,
  input  logic             imem_ack,
  input  logic             dmem_miss,
  input  logic             dmem_ack,
  input  logic             MEM_WB_Halt,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             MEM_WB_bubble,
  output logic             halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);
  import hazard_ctrl_pkg::*;

  hz_state_e state_q, state_d;
  logic      ipend_q, ipend_d;
  hz_ctl_t   ctl;
  logic      lu;
  logic      branch_flush;
  logic      fetch_pend;

  hazard_lu_detect #(.REG_W(REG_W)) u_lu (
    .rs_i       (IF_ID_Rs),
    .rt_i       (IF_ID_Rt),
    .rs_valid_i (IF_ID_RsValid),
    .rt_valid_i (IF_ID_RtValid),
    .rd_i       (ID_EX_Rd),
    .mem_read_i (ID_EX_MemRead),
    .lu_o       (lu)
  );

  // A fetch miss parked during DWAIT that has not been acknowledged yet.
  assign fetch_pend = ipend_q & ~imem_ack;

  // Sequencer state and parked-fetch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ipend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ipend_q <= ipend_d;
    end
  end

  // Next state and per-stage controls; priority HALT > data wait > load-use
  // > fetch wait > taken branch.
  always_comb begin
    ctl          = ctl_normal();
    branch_flush = 1'b0;
    state_d      = state_q;
    ipend_d      = ipend_q;
    if (rst) begin
      ctl     = ctl_reset();
      state_d = RUN;
      ipend_d = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (dmem_miss) begin
            ctl     = ctl_freeze();
            state_d = DWAIT;
            ipend_d = imem_miss;
          end else if (lu) begin
            // Branch in ID is re-evaluated once the bubble has passed.
            ctl = ctl_stall();
          end else if (imem_miss) begin
            ctl     = ctl_stall();
            state_d = IWAIT;
          end else if (branch_taken) begin
            ctl          = ctl_branch();
            branch_flush = 1'b1;
          end
        end
        IWAIT: begin
          if (dmem_miss) begin
            // A fetch ack landing this same cycle is already held by the
            // fetch unit, so only a still-outstanding fetch is parked.
            ctl     = ctl_freeze();
            state_d = DWAIT;
            ipend_d = ~imem_ack;
          end else if (!imem_ack) begin
            ctl = ctl_stall();
          end else begin
            state_d = RUN;
            if (lu) begin
              ctl = ctl_stall();
            end else if (branch_taken) begin
              // Fetched word is on the wrong path: drop it and redirect.
              ctl          = ctl_branch();
              branch_flush = 1'b1;
            end
          end
        end
        DWAIT: begin
          ctl = ctl_freeze();
          if (imem_ack) begin
            ipend_d = 1'b0;
          end
          if (dmem_ack) begin
            // Ack cycle behaves like RUN without a data miss; a fetch still
            // outstanding holds the front end exactly like a fresh miss.
            ipend_d = 1'b0;
            if (fetch_pend || lu || imem_miss) begin
              ctl = ctl_stall();
            end else if (branch_taken) begin
              ctl          = ctl_branch();
              branch_flush = 1'b1;
            end else begin
              ctl = ctl_normal();
            end
            if (fetch_pend || (!lu && imem_miss)) begin
              state_d = IWAIT;
            end else begin
              state_d = RUN;
            end
          end
        end
        HALT: begin
          ctl = ctl_halt();
        end
        default: begin
          ctl     = ctl_reset();
          state_d = RUN;
          ipend_d = 1'b0;
        end
      endcase
      if (MEM_WB_Halt && (state_q != HALT)) begin
        state_d = HALT;
        ipend_d = 1'b0;
      end
    end
  end

  assign pc_write      = ctl.pc_write;
  assign IF_ID_write   = ctl.if_id_write;
  assign ID_EX_write   = ctl.id_ex_write;
  assign EX_MEM_write  = ctl.ex_mem_write;
  assign IF_ID_flush   = ctl.if_id_flush;
  assign ID_EX_bubble  = ctl.id_ex_bubble;
  assign MEM_WB_bubble = ctl.mem_wb_bubble;
  assign halted        = ctl.halted;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Saturating counter updates; HALT never stalls or flushes so both hold.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((state_q != HALT) && !ctl.pc_write && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (branch_flush && (flush_q != '1)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  logic [CNT_W-1:0] perf_unused;
  assign perf_unused = {{(CNT_W-1){1'b0}}, branch_flush};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a reference model that tracks
// outstanding memory requests rather than controller states.
module tb_hazard_ctrl;
  localparam int REG_W = 4;
  localparam int CNT_W = 16;

  // Expected control vectors {pc,ifid,idex,exmem,flush,idexb,memwbb,halted}
  localparam logic [7:0] NRM_V = 8'hF0;
  localparam logic [7:0] STL_V = 8'h34;
  localparam logic [7:0] FRZ_V = 8'h02;
  localparam logic [7:0] BR_V  = 8'hF8;
  localparam logic [7:0] RST_V = 8'h7E;
  localparam logic [7:0] HLT_V = 8'h01;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rd;
  logic IF_ID_RsValid, IF_ID_RtValid, ID_EX_MemRead;
  logic branch_taken, imem_miss, imem_ack, dmem_miss, dmem_ack, MEM_WB_Halt;
  logic pc_write, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic IF_ID_flush, ID_EX_bubble, MEM_WB_bubble, halted;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_RsValid(IF_ID_RsValid), .IF_ID_RtValid(IF_ID_RtValid),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead),
    .branch_taken(branch_taken), .imem_miss(imem_miss), .imem_ack(imem_ack),
    .dmem_miss(dmem_miss), .dmem_ack(dmem_ack), .MEM_WB_Halt(MEM_WB_Halt),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .MEM_WB_bubble(MEM_WB_bubble),
    .halted(halted)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: halted flag, outstanding data access, outstanding fetch.
  bit m_halted, m_dwait, m_fout;
  int m_stall, m_flush;
  logic [7:0] last_obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic idle();
    rst = 1'b0; IF_ID_Rs = '0; IF_ID_Rt = '0; ID_EX_Rd = '0;
    IF_ID_RsValid = 1'b0; IF_ID_RtValid = 1'b0; ID_EX_MemRead = 1'b0;
    branch_taken = 1'b0; imem_miss = 1'b0; imem_ack = 1'b0;
    dmem_miss = 1'b0; dmem_ack = 1'b0; MEM_WB_Halt = 1'b0;
  endtask

  // One clock: predict, compare outputs mid-cycle, advance model at the edge.
  task automatic step(input string tag);
    logic [7:0] e, o;
    bit lu, wf, nm, n_halt, n_dw, n_fo;
    int n_st, n_fl;
    #2;
    lu = ID_EX_MemRead && (ID_EX_Rd != 0) &&
         ((IF_ID_RsValid && IF_ID_Rs == ID_EX_Rd) || (IF_ID_RtValid && IF_ID_Rt == ID_EX_Rd));
    n_halt = m_halted; n_dw = m_dwait; n_fo = m_fout; n_st = m_stall; n_fl = m_flush;
    e = NRM_V;
    if (rst) begin
      e = RST_V; n_halt = 0; n_dw = 0; n_fo = 0; n_st = 0; n_fl = 0;
    end else if (m_halted) begin
      e = HLT_V;
    end else begin
      if (m_dwait && !dmem_ack) begin
        e = FRZ_V;
        if (imem_ack) n_fo = 0;
      end else if (!m_dwait && dmem_miss) begin
        e = FRZ_V; n_dw = 1;
        n_fo = m_fout ? !imem_ack : imem_miss;
      end else begin
        wf = m_fout && !imem_ack;
        nm = imem_miss && !(m_fout && !m_dwait);
        n_dw = 0;
        if (wf)                begin e = STL_V; n_fo = 1; end
        else if (lu)           begin e = STL_V; n_fo = 0; end
        else if (nm)           begin e = STL_V; n_fo = 1; end
        else if (branch_taken) begin e = BR_V;  n_fo = 0; n_fl = sat_inc(m_flush); end
        else                   begin e = NRM_V; n_fo = 0; end
      end
      if (!e[7]) n_st = sat_inc(m_stall);
      if (MEM_WB_Halt) begin n_halt = 1; n_dw = 0; n_fo = 0; end
    end
    o = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
         IF_ID_flush, ID_EX_bubble, MEM_WB_bubble, halted};
    last_obs = o;
    check_eq(tag, 32'(o), 32'(e));
`ifdef HAZARD_PERF_EN
    check_eq({tag, "_stall_cnt"}, 32'(stall_cycles), 32'(m_stall));
    check_eq({tag, "_flush_cnt"}, 32'(flush_count), 32'(m_flush));
`endif
    @(posedge clk);
    m_halted = n_halt; m_dwait = n_dw; m_fout = n_fo; m_stall = n_st; m_flush = n_fl;
    #1;
  endtask

  initial begin
    int frozen, hcnt;
    idle();
    rst = 1'b1;
    m_halted = 0; m_dwait = 0; m_fout = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); @(posedge clk); #1;

    // Reset outputs while rst is held.
    step("reset");
    check_eq("reset_halted", 32'(last_obs[0]), 32'd0);
    idle();

    // Load r3 in EX, add reading r3 as Rt in ID.
    ID_EX_MemRead = 1; ID_EX_Rd = 4'd3; IF_ID_Rt = 4'd3; IF_ID_RtValid = 1;
    step("lu_stall");
    check_eq("lu_pcw", 32'(last_obs[7]), 32'd0);
    check_eq("lu_bubble", 32'(last_obs[2]), 32'd1);
    idle(); step("lu_after");
    check_eq("lu_after_pcw", 32'(last_obs[7]), 32'd1);
    ID_EX_MemRead = 1; ID_EX_Rd = 4'd0; IF_ID_Rt = 4'd0; IF_ID_RtValid = 1;
    step("lu_r0");
    check_eq("lu_r0_pcw", 32'(last_obs[7]), 32'd1);

    // Taken branch in RUN.
    idle(); branch_taken = 1; step("branch");
    check_eq("branch_flush", 32'(last_obs[3]), 32'd1);
    idle(); step("branch_after");

    // Data miss with three wait cycles before the ack.
    frozen = 0;
    dmem_miss = 1; step("dmiss");
    if (!last_obs[4]) frozen++;
    idle();
    for (int i = 0; i < 3; i++) begin
      step("dwait");
      if (!last_obs[4]) frozen++;
    end
    dmem_ack = 1; step("dack");
    if (!last_obs[4]) frozen++;
    idle(); step("dack_after");
    check_eq("dmiss_frozen", 32'(frozen), 32'd4);
    check_eq("dmiss_run", 32'(last_obs[7]), 32'd1);

    // Fetch and data miss together, fetch acked during the data wait.
    imem_miss = 1; dmem_miss = 1; step("idmiss");
    idle(); step("dw1");
    imem_ack = 1; step("dw_iack");
    idle(); dmem_ack = 1; step("dw_dack");
    idle(); step("dw_run");
    check_eq("dw_to_run", 32'(last_obs[7]), 32'd1);

    // Same, without the fetch ack: must fall into the fetch wait.
    imem_miss = 1; dmem_miss = 1; step("idmiss2");
    idle(); step("dw2");
    dmem_ack = 1; step("dw2_dack");
    idle(); step("dw2_iwait");
    check_eq("dw_to_iwait", 32'(last_obs[7]), 32'd0);
    imem_ack = 1; step("iw_ack");
    idle(); step("iw_run");

    // Taken branch arriving with the fetch ack.
    imem_miss = 1; step("imiss");
    idle(); step("iwait");
    imem_ack = 1; branch_taken = 1; step("iwait_ack_br");
    check_eq("iwait_br", 32'({last_obs[7], last_obs[3]}), 32'd3);
    idle(); step("iwait_br_after");

    // HLT retires: halted for the following cycles regardless of inputs.
    MEM_WB_Halt = 1; step("halt_in");
    hcnt = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      dmem_miss = 1'($urandom); imem_miss = 1'($urandom); branch_taken = 1'($urandom);
      step("halted");
      if (last_obs == HLT_V) hcnt++;
    end
    check_eq("halt_cycles", 32'(hcnt), 32'd10);
    idle(); rst = 1; step("halt_rst");
    idle(); step("post_rst");
    check_eq("post_rst_halted", 32'(last_obs[0]), 32'd0);
`ifdef HAZARD_PERF_EN
    check_eq("post_rst_stall_cnt", 32'(stall_cycles), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 19) == 0);
      IF_ID_Rs = REG_W'($urandom_range(0, 3));
      IF_ID_Rt = REG_W'($urandom_range(0, 3));
      ID_EX_Rd = REG_W'($urandom_range(0, 3));
      IF_ID_RsValid = 1'($urandom); IF_ID_RtValid = 1'($urandom);
      ID_EX_MemRead = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      imem_miss     = ($urandom_range(0, 5) == 0);
      imem_ack      = ($urandom_range(0, 2) == 0);
      dmem_miss     = ($urandom_range(0, 7) == 0);
      dmem_ack      = ($urandom_range(0, 2) == 0);
      MEM_WB_Halt   = ($urandom_range(0, 149) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
